// File: rtl/weighted_round_robin_arbiter.sv
// Weighted round-robin arbiter. The owner keeps a registered one-hot grant for up to
// its weight of consecutive transfers. Priority then rotates to the requester after it.
module weighted_round_robin_arbiter #(
  parameter int SIZE         = 4,
  parameter int WEIGHT_WIDTH = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [SIZE-1:0]              requests,
  input  logic [SIZE*WEIGHT_WIDTH-1:0] weights,
  input  logic                         transfer,
  output logic [SIZE-1:0]              grant,
  output logic                         grant_valid,
  output logic [$clog2(SIZE)-1:0]      grant_index,
  output logic [WEIGHT_WIDTH-1:0]      quota_remaining
);

  localparam int IDX_W = $clog2(SIZE);

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_OWNED = 1'b1;

  logic                    r_state;
  logic [SIZE-1:0]         r_grant;
  logic                    r_grant_valid;
  logic [IDX_W-1:0]        r_grant_index;
  logic [WEIGHT_WIDTH-1:0] r_quota;
  logic [IDX_W-1:0]        r_pointer;

  logic                    w_release;
  logic [IDX_W-1:0]        w_next_ptr;
  logic [IDX_W-1:0]        w_arb_ptr;
  logic [IDX_W:0]          w_sum;
  logic [IDX_W-1:0]        w_idx;
  logic                    w_found;
  logic [IDX_W-1:0]        w_winner;
  logic [SIZE-1:0]         w_winner_onehot;
  logic [WEIGHT_WIDTH-1:0] w_weight_arr [SIZE];
  logic [WEIGHT_WIDTH-1:0] w_weight;
  logic [WEIGHT_WIDTH-1:0] w_load_quota;

  // A withdrawn request releases even when a transfer lands in the same cycle.
  assign w_release = (r_state == ST_OWNED) &&
                     (!requests[r_grant_index] ||
                      (transfer && (r_quota == WEIGHT_WIDTH'(1))));

  assign w_next_ptr = (r_grant_index == IDX_W'(SIZE - 1)) ? '0
                                                          : r_grant_index + IDX_W'(1);

  // While owned, arbitration only matters on release, so it always searches past the owner.
  assign w_arb_ptr = (r_state == ST_OWNED) ? w_next_ptr : r_pointer;

  // NOTE: every always_comb output gets a default before the loop so no latch is inferred.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_sum    = '0;
    w_idx    = '0;
    for (int i = 0; i < SIZE; i++) begin
      w_sum = {1'b0, w_arb_ptr} + (IDX_W + 1)'(i);
      if (w_sum >= (IDX_W + 1)'(SIZE)) begin
        w_sum = w_sum - (IDX_W + 1)'(SIZE);
      end
      w_idx = w_sum[IDX_W-1:0];
      if (!w_found && requests[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < SIZE; i++) begin
      w_weight_arr[i] = weights[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
    end
  end

  assign w_weight        = w_weight_arr[w_winner];
  assign w_load_quota    = (w_weight == '0) ? WEIGHT_WIDTH'(1) : w_weight;
  assign w_winner_onehot = SIZE'(1) << w_winner;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_grant       <= '0;
      r_grant_valid <= 1'b0;
      r_grant_index <= '0;
      r_quota       <= '0;
      r_pointer     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_state       <= ST_OWNED;
            r_grant       <= w_winner_onehot;
            r_grant_valid <= 1'b1;
            r_grant_index <= w_winner;
            r_quota       <= w_load_quota;
          end
        end
        default: begin
          if (w_release) begin
            r_pointer <= w_next_ptr;
            if (w_found) begin
              r_grant       <= w_winner_onehot;
              r_grant_valid <= 1'b1;
              r_grant_index <= w_winner;
              r_quota       <= w_load_quota;
            end else begin
              r_state       <= ST_IDLE;
              r_grant       <= '0;
              r_grant_valid <= 1'b0;
              r_grant_index <= '0;
              r_quota       <= '0;
            end
          end else if (transfer) begin
            r_quota <= r_quota - WEIGHT_WIDTH'(1);
          end
        end
      endcase
    end
  end

  assign grant           = r_grant;
  assign grant_valid     = r_grant_valid;
  assign grant_index     = r_grant_index;
  assign quota_remaining = r_quota;

endmodule

// File: tb/tb_weighted_round_robin_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a cycle-level
// reference model that tracks owner, quota and pointer as plain integers.
module tb_weighted_round_robin_arbiter;

  localparam int SIZE = 4;
  localparam int WW   = 4;
  localparam int IW   = 2;

  logic             clock = 1'b0;
  logic             reset;
  logic [SIZE-1:0]  requests;
  logic [SIZE*WW-1:0] weights;
  logic             transfer;
  logic [SIZE-1:0]  grant;
  logic             grant_valid;
  logic [IW-1:0]    grant_index;
  logic [WW-1:0]    quota_remaining;

  weighted_round_robin_arbiter #(.SIZE(SIZE), .WEIGHT_WIDTH(WW)) dut (
    .clock           (clock),
    .reset           (reset),
    .requests        (requests),
    .weights         (weights),
    .transfer        (transfer),
    .grant           (grant),
    .grant_valid     (grant_valid),
    .grant_index     (grant_index),
    .quota_remaining (quota_remaining)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: owner is -1 when idle.
  int m_owner;
  int m_quota;
  int m_ptr;

  // Starvation tracking, measured on the DUT's own grant.
  bit track;
  int wait_cnt [SIZE];
  int starve_viol;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int eff_weight(input int i);
    int w;
    w = int'(weights[i*WW +: WW]);
    return (w == 0) ? 1 : w;
  endfunction

  function automatic int pick(input int ptr, input logic [SIZE-1:0] req);
    for (int k = 0; k < SIZE; k++) begin
      int j;
      j = (ptr + k) % SIZE;
      if (req[j]) return j;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_quota = 0;
    m_ptr   = 0;
  endtask

  // Next model state from the inputs currently applied.
  task automatic model_step();
    int w;
    if (m_owner < 0) begin
      w = pick(m_ptr, requests);
      if (w >= 0) begin
        m_owner = w;
        m_quota = eff_weight(w);
      end
    end else if (!requests[m_owner] || (transfer && m_quota == 1)) begin
      m_ptr = (m_owner + 1) % SIZE;
      w = pick(m_ptr, requests);
      if (w >= 0) begin
        m_owner = w;
        m_quota = eff_weight(w);
      end else begin
        m_owner = -1;
        m_quota = 0;
      end
    end else if (transfer) begin
      m_quota = m_quota - 1;
    end
  endtask

  task automatic compare_all(input string tag);
    logic [SIZE-1:0] eg;
    eg = (m_owner < 0) ? '0 : SIZE'(1) << m_owner;
    check({tag, "_grant"}, 32'(grant), 32'(eg));
    check({tag, "_valid"}, 32'(grant_valid), 32'(m_owner >= 0));
    check({tag, "_index"}, 32'(grant_index), (m_owner < 0) ? 0 : m_owner);
    check({tag, "_quota"}, 32'(quota_remaining), m_quota);
  endtask

  task automatic starve_update();
    int bound;
    for (int i = 0; i < SIZE; i++) begin
      if (requests[i] && !(grant_valid && int'(grant_index) == i)) begin
        if (grant_valid && transfer) wait_cnt[i]++;
      end else begin
        wait_cnt[i] = 0;
      end
      bound = 0;
      for (int j = 0; j < SIZE; j++) if (j != i) bound += eff_weight(j);
      if (wait_cnt[i] > bound) starve_viol++;
    end
  endtask

  task automatic tick(input string tag);
    model_step();
    if (track) starve_update();
    @(posedge clock);
    #1;
    compare_all(tag);
    check({tag, "_onehot"}, 32'($countones(grant) <= 1), 32'd1);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    requests = '0;
    transfer = 1'b0;
    @(posedge clock);
    #1;
    model_reset();
    compare_all("reset");
    reset = 1'b0;
  endtask

  task automatic set_weights(input int w0, input int w1, input int w2, input int w3);
    weights = {WW'(w3), WW'(w2), WW'(w1), WW'(w0)};
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt [SIZE];
    int pos;
    int exp_idx;
    track       = 1'b0;
    starve_viol = 0;
    for (int i = 0; i < SIZE; i++) wait_cnt[i] = 0;
    set_weights(0, 0, 0, 0);

    // Asynchronous reset while requester 2 owns with quota 3.
    set_weights(5, 5, 3, 5);
    do_reset();
    requests = 4'b0100;
    tick("own2");
    check("own2_grant_const", 32'(grant), 32'h4);
    check("own2_quota_const", 32'(quota_remaining), 32'd3);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_grant", 32'(grant), 32'h0);
    check("async_rst_valid", 32'(grant_valid), 32'h0);
    check("async_rst_quota", 32'(quota_remaining), 32'h0);
    model_reset();
    requests = 4'b1111;
    #1;
    reset = 1'b0;
    tick("post_rst");
    check("post_rst_first", 32'(grant), 32'h1);

    // Sole requester re-granted through wrap-around, quota 3,2,1 repeating.
    set_weights(5, 5, 3, 5);
    do_reset();
    requests = 4'b0100;
    transfer = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick("single");
      check("single_grant_const", 32'(grant), 32'h4);
      check("single_quota_const", 32'(quota_remaining), 32'(3 - (k % 3)));
    end

    // Weights 1..4: 10-cycle pattern and exact share over 1000 cycles.
    set_weights(1, 2, 3, 4);
    do_reset();
    requests = 4'b1111;
    transfer = 1'b1;
    for (int i = 0; i < SIZE; i++) cnt[i] = 0;
    for (int k = 0; k < 1000; k++) begin
      tick("wrr");
      if (k < 20) begin
        pos = k % 10;
        exp_idx = (pos < 1) ? 0 : (pos < 3) ? 1 : (pos < 6) ? 2 : 3;
        check("wrr_seq", 32'(grant_index), exp_idx);
      end
      if (grant_valid) cnt[grant_index]++;
    end
    for (int i = 0; i < SIZE; i++) check("wrr_share", cnt[i], 100 * (i + 1));

    // Weight 0 behaves as weight 1.
    set_weights(0, 0, 0, 0);
    do_reset();
    requests = 4'b1111;
    transfer = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick("w0");
      check("w0_grant_const", 32'(grant), 32'(1 << (k % 4)));
      check("w0_quota_const", 32'(quota_remaining), 32'd1);
    end

    // Early withdrawal by requester 1 after two transfers.
    set_weights(7, 4, 5, 6);
    do_reset();
    requests = 4'b0110;
    transfer = 1'b0;
    tick("wd_load");
    check("wd_load_grant", 32'(grant), 32'h2);
    check("wd_load_quota", 32'(quota_remaining), 32'd4);
    transfer = 1'b1;
    tick("wd_x1");
    tick("wd_x2");
    check("wd_after2_quota", 32'(quota_remaining), 32'd2);
    requests = 4'b0100;
    tick("wd_handover");
    check("wd_handover_grant", 32'(grant), 32'h4);
    check("wd_handover_quota", 32'(quota_remaining), 32'd5);
    requests = 4'b1011;
    transfer = 1'b0;
    tick("wd_next");
    check("wd_next_grant", 32'(grant), 32'h8);

    // Stall: grant and quota frozen while transfer is low.
    set_weights(7, 4, 5, 6);
    for (int k = 0; k < 20; k++) begin
      tick("stall");
      check("stall_grant", 32'(grant), 32'h8);
      check("stall_quota", 32'(quota_remaining), 32'd6);
    end

    // Random traffic with fixed weights; starvation bound tracked.
    set_weights($urandom_range(0, 15), $urandom_range(0, 15),
                $urandom_range(0, 15), $urandom_range(0, 15));
    track = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      for (int i = 0; i < SIZE; i++) if ($urandom_range(0, 7) == 0) requests[i] = ~requests[i];
      transfer = ($urandom_range(0, 3) != 0);
      tick("rnd");
    end
    track = 1'b0;
    check("no_starvation", starve_viol, 0);

    // Random traffic with weights changing every cycle; only load-time weights count.
    for (int k = 0; k < 500; k++) begin
      for (int i = 0; i < SIZE; i++) if ($urandom_range(0, 5) == 0) requests[i] = ~requests[i];
      transfer = ($urandom_range(0, 2) != 0);
      weights  = SIZE*WW'($urandom());
      tick("rndw");
    end

    // Transfer while idle is ignored.
    do_reset();
    transfer = 1'b1;
    for (int k = 0; k < 3; k++) tick("idle_xfer");
    check("idle_xfer_valid", 32'(grant_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
